adder_4: RTL and testbench

Registered 4-bit ripple-carry adder: adds two 4-bit unsigned operands and a carry-in, producing a 5-bit sum and a separate carry-out. It serves as a leaf arithmetic block and as the reference ripple-carry datapath for larger adders built from the same full-adder cell. Outputs are registered on a single clock with an asynchronous active-high reset.

---
 rtl/adder_pkg.sv | 7 +
 rtl/full_adder.sv | 15 +
 rtl/adder_4.sv | 43 ++++
 tb/tb_adder_4.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared width constant and operand/result types for the ripple-carry adder family.
package adder_pkg;
    localparam int ADDER4_W = 4;

    typedef logic [ADDER4_W-1:0] operand_t;
    typedef logic [ADDER4_W:0]   result_t;
endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell; the building block of every ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic w_p;

    // Propagate term is shared by the sum and the carry expression.
    assign w_p  = a ^ b;
    assign sum  = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);
endmodule

// File: rtl/adder_4.sv
// Registered 4-bit ripple-carry adder: sum = a + b + cin, captured every rising edge.
module adder_4
    import adder_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDER4_W-1:0] a,
    input  logic [ADDER4_W-1:0] b,
    input  logic                cin,
    output logic [ADDER4_W:0]   sum,
    output logic                cout
);
    logic [ADDER4_W:0] w_carry;
    operand_t          w_s;
    result_t           r_sum;
    logic              r_cout;

    assign w_carry[0] = cin;

    // Carries are chained cell to cell so the critical path is a visible ripple.
    for (genvar i = 0; i < ADDER4_W; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (w_carry[i]),
            .sum  (w_s[i]),
            .cout (w_carry[i+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= {w_carry[ADDER4_W], w_s};
            r_cout <= w_carry[ADDER4_W];
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
endmodule

// File: tb/tb_adder_4.sv
// Testbench for adder_4: directed boundary cases, random back-to-back traffic and an exhaustive sweep.
module tb_adder_4;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] a   = 4'd0;
    logic [3:0] b   = 4'd0;
    logic       cin = 1'b0;
    logic [4:0] sum;
    logic       cout;

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0] exp_q[$];

    adder_4 dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer addition of the operands.
    function automatic logic [4:0] ref_add(input logic [3:0] x, input logic [3:0] y, input logic c);
        int r;
        r = int'(x) + int'(y) + int'(c);
        return r[4:0];
    endfunction

    // Drive inputs away from the active edge, then land 1 time unit after the capturing edge.
    task automatic apply(input logic [3:0] x, input logic [3:0] y, input logic c);
        @(negedge clk);
        a = x; b = y; cin = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        a = 4'd9; b = 4'd9; cin = 1'b1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (sum !== 5'd0 || cout !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_async: sum=%0d cout=%b, want sum=0 cout=0", sum, cout);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (sum !== 5'd0 || cout !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_hold: sum=%0d cout=%b, want sum=0 cout=0", sum, cout);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (sum !== 5'd19 || cout !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release: sum=%0d cout=%b, want sum=19 cout=1", sum, cout);
        end
    endtask

    task automatic test_basic;
        apply(4'd4, 4'd5, 1'b0);
        n_checks++;
        if (sum !== 5'd9 || cout !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_4_5: sum=%0d cout=%b, want sum=9 cout=0", sum, cout);
        end
        apply(4'd15, 4'd3, 1'b0);
        n_checks++;
        if (sum !== 5'd18 || cout !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_15_3: sum=%0d cout=%b, want sum=18 cout=1", sum, cout);
        end
    endtask

    task automatic test_carry_in;
        apply(4'd15, 4'd0, 1'b1);
        n_checks++;
        if (sum !== 5'd16 || cout !== 1'b1) begin
            n_errors++;
            $display("FAIL cin_ripple: sum=%0d cout=%b, want sum=16 cout=1", sum, cout);
        end
        apply(4'd0, 4'd0, 1'b1);
        n_checks++;
        if (sum !== 5'd1 || cout !== 1'b0) begin
            n_errors++;
            $display("FAIL cin_only: sum=%0d cout=%b, want sum=1 cout=0", sum, cout);
        end
    endtask

    task automatic test_extremes;
        apply(4'd15, 4'd15, 1'b1);
        n_checks++;
        if (sum !== 5'd31 || cout !== 1'b1) begin
            n_errors++;
            $display("FAIL max: sum=%0d cout=%b, want sum=31 cout=1", sum, cout);
        end
        apply(4'd0, 4'd0, 1'b0);
        n_checks++;
        if (sum !== 5'd0 || cout !== 1'b0) begin
            n_errors++;
            $display("FAIL min: sum=%0d cout=%b, want sum=0 cout=0", sum, cout);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] x, y;
        logic       c;
        logic [4:0] prev, e;
        prev = 5'd0;
        for (int i = 0; i < 40; i++) begin
            x = 4'($urandom_range(0, 15));
            y = 4'($urandom_range(0, 15));
            c = 1'($urandom_range(0, 1));
            exp_q.push_back(ref_add(x, y, c));
            @(negedge clk);
            a = x; b = y; cin = c;
            #1;
            // New inputs must not reach the outputs before the next edge.
            n_checks++;
            if (sum !== prev) begin
                n_errors++;
                $display("FAIL b2b_hold[%0d]: sum=%0d, want previous %0d", i, sum, prev);
            end
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (sum !== e || cout !== e[4]) begin
                n_errors++;
                $display("FAIL b2b[%0d]: %0d+%0d+%0d sum=%0d cout=%b, want sum=%0d cout=%b",
                         i, x, y, c, sum, cout, e, e[4]);
            end
            n_checks++;
            if (cout !== sum[4]) begin
                n_errors++;
                $display("FAIL b2b_cout_inv[%0d]: cout=%b sum[4]=%b", i, cout, sum[4]);
            end
            prev = e;
        end
    endtask

    task automatic test_exhaustive;
        logic [3:0] x, y;
        logic       c;
        logic [4:0] e;
        for (int v = 0; v < 512; v++) begin
            x = 4'(v >> 5);
            y = 4'(v >> 1);
            c = 1'(v);
            apply(x, y, c);
            e = ref_add(x, y, c);
            n_checks++;
            if (sum !== e || cout !== e[4]) begin
                n_errors++;
                $display("FAIL exh %0d+%0d+%0d: sum=%0d cout=%b, want sum=%0d cout=%b",
                         x, y, c, sum, cout, e, e[4]);
            end
            if (v == 300) begin
                @(negedge clk);
                a = 4'd12; b = 4'd7; cin = 1'b1;
                #2;
                rst = 1'b1;
                #1;
                n_checks++;
                if (sum !== 5'd0 || cout !== 1'b0) begin
                    n_errors++;
                    $display("FAIL mid_reset_async: sum=%0d cout=%b, want sum=0 cout=0", sum, cout);
                end
                @(posedge clk);
                #1;
                n_checks++;
                if (sum !== 5'd0 || cout !== 1'b0) begin
                    n_errors++;
                    $display("FAIL mid_reset_hold: sum=%0d cout=%b, want sum=0 cout=0", sum, cout);
                end
                @(negedge clk);
                rst = 1'b0;
                a = 4'd6; b = 4'd11; cin = 1'b0;
                #1;
                n_checks++;
                if (sum !== 5'd0 || cout !== 1'b0) begin
                    n_errors++;
                    $display("FAIL mid_reset_no_retro: sum=%0d cout=%b, want sum=0 cout=0", sum, cout);
                end
                @(posedge clk);
                #1;
                e = ref_add(4'd6, 4'd11, 1'b0);
                n_checks++;
                if (sum !== e || cout !== e[4]) begin
                    n_errors++;
                    $display("FAIL mid_reset_resume: sum=%0d cout=%b, want sum=%0d cout=%b",
                             sum, cout, e, e[4]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_in();
        test_extremes();
        test_back_to_back();
        test_exhaustive();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
